// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | score_pkg : FSM encoding and seven-segment constants for the counter |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package score_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns; the pattern for digit d sits at [7*d +: 7].
    localparam logic [69:0] SEG_TABLE = {
        7'h18, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] segs;
        segs = SEG_BLANK;
        for (int d = 0; d < 10; d++) begin
            if (digit == 4'(d)) begin
                segs = SEG_TABLE[7*d +: 7];
            end
        end
        return segs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_seg : one BCD digit to active-low segments; non-BCD is blank  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module bcd_to_seg
    import score_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segs
);

    assign segs = seg_of(bcd);

endmodule
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_score_counter : N-digit BCD score counter with high score and    |
// |                     registered seven-segment output                  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int SATURATE      = 0,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    collided,
    input  logic                    restart,
    input  logic                    show_high,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    new_high,
    output logic                    overflow,
    output logic                    running,
    output logic [7*NUM_DIGITS-1:0] hex_segs
);

    localparam int CW = 4*NUM_DIGITS;
    localparam int SW = 7*NUM_DIGITS;

    function automatic logic [SW-1:0] segs_reset();
        logic [SW-1:0] r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            r[7*k +: 7] = (k == 0 || BLANK_LEADING == 0) ? SEG_TABLE[6:0] : SEG_BLANK;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] SEGS_RST = segs_reset();

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] high_q, high_d;
    logic          new_high_q, new_high_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] segs_q, segs_d;

    logic                  inc;
    logic [NUM_DIGITS:0]   carry;
    logic [CW-1:0]         count_inc;
    logic [CW-1:0]         disp_src;
    logic [SW-1:0]         segs_raw;

    assign inc      = (state_q == ST_RUN) && tick && !collided;
    assign carry[0] = inc;

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_inc
            assign count_inc[4*k +: 4] = !carry[k]                  ? count_q[4*k +: 4] :
                                         (count_q[4*k +: 4] == 4'd9) ? 4'd0 :
                                                                       count_q[4*k +: 4] + 4'd1;
            assign carry[k+1] = carry[k] && (count_q[4*k +: 4] == 4'd9);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_RUN: begin
                if (collided) begin
                    state_d = ST_CMP;
                end else begin
                    if (carry[NUM_DIGITS]) begin
                        overflow_d = 1'b1;
                    end
                    count_d = (carry[NUM_DIGITS] && SATURATE != 0) ? count_q : count_inc;
                end
            end
            ST_CMP: begin
                // Digits are always 0-9, so a plain binary compare orders BCD correctly.
                if (count_q > high_q) begin
                    high_d     = count_q;
                    new_high_d = 1'b1;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (restart) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    new_high_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign disp_src = show_high ? high_q : count_q;

    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_disp
            bcd_to_seg u_seg (
                .bcd  (disp_src[4*k +: 4]),
                .segs (segs_raw[7*k +: 7])
            );
            if (k == 0 || BLANK_LEADING == 0) begin : g_show
                assign segs_d[7*k +: 7] = segs_raw[7*k +: 7];
            end else begin : g_blank
                // Blank when this digit and every higher digit are zero.
                assign segs_d[7*k +: 7] = (disp_src[CW-1:4*k] == '0) ? SEG_BLANK
                                                                     : segs_raw[7*k +: 7];
            end
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            overflow_q <= 1'b0;
            segs_q     <= SEGS_RST;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            overflow_q <= overflow_d;
            segs_q     <= segs_d;
        end
    end

    assign count_bcd = count_q;
    assign high_bcd  = high_q;
    assign new_high  = new_high_q;
    assign overflow  = overflow_q;
    assign running   = (state_q == ST_RUN);
    assign hex_segs  = segs_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_score_counter : directed scoreboard bench, 3-digit main DUT   |
// |                        plus 2-digit wrap and saturate instances      |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_bcd_score_counter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0, collided = 1'b0, restart = 1'b0, show_high = 1'b0;
    logic tick2 = 1'b0, collided2 = 1'b0, restart2 = 1'b0;

    logic [11:0] count_bcd, high_bcd;
    logic        new_high, overflow, running;
    logic [20:0] hex_segs;

    logic [7:0]  count_w, high_w, count_s, high_s;
    logic        new_high_w, overflow_w, running_w;
    logic        new_high_s, overflow_s, running_s;
    logic [13:0] segs_w, segs_s;

    int errors = 0;
    int checks = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_score_counter #(.NUM_DIGITS(3), .SATURATE(0), .BLANK_LEADING(1)) dut (
        .CLOCK_50(clk), .reset(reset), .tick(tick), .collided(collided),
        .restart(restart), .show_high(show_high), .count_bcd(count_bcd),
        .high_bcd(high_bcd), .new_high(new_high), .overflow(overflow),
        .running(running), .hex_segs(hex_segs)
    );

    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(0), .BLANK_LEADING(1)) dut_wrap (
        .CLOCK_50(clk), .reset(reset), .tick(tick2), .collided(collided2),
        .restart(restart2), .show_high(1'b0), .count_bcd(count_w),
        .high_bcd(high_w), .new_high(new_high_w), .overflow(overflow_w),
        .running(running_w), .hex_segs(segs_w)
    );

    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(1), .BLANK_LEADING(1)) dut_sat (
        .CLOCK_50(clk), .reset(reset), .tick(tick2), .collided(collided2),
        .restart(restart2), .show_high(1'b0), .count_bcd(count_s),
        .high_bcd(high_s), .new_high(new_high_s), .overflow(overflow_s),
        .running(running_s), .hex_segs(segs_s)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        step(n);
        tick = 1'b0;
    endtask

    task automatic ticks2(input int n);
        tick2 = 1'b1;
        step(n);
        tick2 = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        #2;
        reset = 1'b1;
        step(2);
        push("rst_count", 32'h0);        check(32'(count_bcd));
        push("rst_high", 32'h0);         check(32'(high_bcd));
        push("rst_newhigh", 32'h0);      check(32'(new_high));
        push("rst_overflow", 32'h0);     check(32'(overflow));
        push("rst_running", 32'h1);      check(32'(running));
        push("rst_segs", 32'({7'h7F, 7'h7F, 7'h40})); check(32'(hex_segs));
        reset = 1'b0;
        step(1);

        push("count_123", 32'h123);
        ticks(123);
        check(32'(count_bcd));
        push("segs_123", 32'({7'h79, 7'h24, 7'h30}));
        step(1);
        check(32'(hex_segs));

        do_reset();
        push("count_009", 32'h009); ticks(9);  check(32'(count_bcd));
        push("count_010", 32'h010); ticks(1);  check(32'(count_bcd));
        push("count_099", 32'h099); ticks(89); check(32'(count_bcd));
        push("count_100", 32'h100); ticks(1);  check(32'(count_bcd));
        push("segs_100", 32'({7'h79, 7'h40, 7'h40}));
        step(1);
        check(32'(hex_segs));

        do_reset();
        ticks(42);
        tick = 1'b1;
        collided = 1'b1;
        push("cmp_count", 32'h042);
        push("cmp_running", 32'h0);
        step(1);
        check(32'(count_bcd));
        check(32'(running));
        push("hold_high", 32'h042);
        push("hold_newhigh", 32'h1);
        step(1);
        check(32'(high_bcd));
        check(32'(new_high));
        push("hold_frozen", 32'h042);
        step(3);
        check(32'(count_bcd));
        tick = 1'b0;
        collided = 1'b0;

        restart = 1'b1;
        push("restart_count", 32'h0);
        push("restart_running", 32'h1);
        push("restart_newhigh", 32'h0);
        step(1);
        restart = 1'b0;
        check(32'(count_bcd));
        check(32'(running));
        check(32'(new_high));
        ticks(17);
        collided = 1'b1;
        push("low_high", 32'h042);
        push("low_newhigh", 32'h0);
        step(2);
        collided = 1'b0;
        check(32'(high_bcd));
        check(32'(new_high));
        push("segs_17", 32'({7'h7F, 7'h79, 7'h78}));
        check(32'(hex_segs));
        show_high = 1'b1;
        push("segs_show_high", 32'({7'h7F, 7'h19, 7'h24}));
        step(1);
        check(32'(hex_segs));
        show_high = 1'b0;

        restart = 1'b1;
        step(1);
        restart = 1'b0;
        ticks(42);
        collided = 1'b1;
        push("equal_newhigh", 32'h0);
        push("equal_high", 32'h042);
        step(2);
        collided = 1'b0;
        check(32'(new_high));
        check(32'(high_bcd));

        restart = 1'b1;
        step(1);
        restart = 1'b0;
        ticks(55);
        collided = 1'b1;
        push("cmp55_running", 32'h0);
        step(1);
        check(32'(running));
        collided = 1'b0;
        reset = 1'b1;
        #1;
        push("async_count", 32'h0);      check(32'(count_bcd));
        push("async_high", 32'h0);       check(32'(high_bcd));
        push("async_running", 32'h1);    check(32'(running));
        push("async_newhigh", 32'h0);    check(32'(new_high));
        push("async_segs", 32'({7'h7F, 7'h7F, 7'h40})); check(32'(hex_segs));
        step(1);
        reset = 1'b0;
        step(1);

        push("wrap_99", 32'h99);  push("sat_99", 32'h99);  push("wrap_ov0", 32'h0);
        ticks2(99);
        check(32'(count_w)); check(32'(count_s)); check(32'(overflow_w));
        push("wrap_00", 32'h00);  push("wrap_ov1", 32'h1);
        push("sat_hold99", 32'h99); push("sat_ov1", 32'h1);
        ticks2(1);
        check(32'(count_w)); check(32'(overflow_w));
        check(32'(count_s)); check(32'(overflow_s));
        push("ov_sticky", 32'h1);
        step(2);
        check(32'(overflow_w));
        collided2 = 1'b1;
        step(2);
        collided2 = 1'b0;
        restart2 = 1'b1;
        push("wrap_ov_clr", 32'h0); push("sat_ov_clr", 32'h0); push("sat_count_clr", 32'h0);
        step(1);
        restart2 = 1'b0;
        check(32'(overflow_w)); check(32'(overflow_s)); check(32'(count_s));

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
